// File: rtl/task_sequencer_pkg.sv
// Shared types and helpers for the task sequencer: FSM state encoding, the
// task-index width helper and the ordered task search. Optional: TASK_SEQ_TIMEOUT_EN.
package task_seq_pkg;

   localparam int MAX_TASKS              = 16;
   localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_DONE
`ifdef TASK_SEQ_TIMEOUT_EN
      , ST_FAULT
`endif
   } state_e;

   function automatic int task_w_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Lowest set bit of mask at position >= from, or -1 when there is none.
   function automatic int lowest_set_from(input logic [MAX_TASKS-1:0] mask, input int from);
      int r;
      r = -1;
      for (int i = MAX_TASKS - 1; i >= 0; i--) begin
         if (i >= from && mask[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/task_sequencer_if.sv
// Task-channel bundle between the sequencer (master) and the task engines (slave):
// start pulses, finish flags and each engine's memory write request.
interface task_sequencer_if #(
   parameter int NUM_TASKS = 3,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8
);
   logic [NUM_TASKS-1:0]        task_start;
   logic [NUM_TASKS-1:0]        task_finish;
   logic [NUM_TASKS-1:0]        task_we;
   logic [NUM_TASKS*ADDR_W-1:0] task_addr;
   logic [NUM_TASKS*DATA_W-1:0] task_wdata;

   modport master (
      output task_start,
      input  task_finish, task_we, task_addr, task_wdata
   );

   modport slave (
      input  task_start,
      output task_finish, task_we, task_addr, task_wdata
   );
endinterface

// File: rtl/task_port_mux.sv
// NUM_TASKS-to-1 combinational mux onto the shared memory write port; the port
// reads as all zeros whenever en is low.
module task_port_mux #(
   parameter int NUM_TASKS = 3,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int SEL_W     = 2
) (
   input  logic                        en,
   input  logic [SEL_W-1:0]            sel,
   input  logic [NUM_TASKS-1:0]        we,
   input  logic [NUM_TASKS*ADDR_W-1:0] addr,
   input  logic [NUM_TASKS*DATA_W-1:0] wdata,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata
);

   always_comb begin
      // NOTE: outputs are defaulted before the loop so no path leaves them
      // unassigned, which would otherwise infer a latch.
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (en) begin
         for (int i = 0; i < NUM_TASKS; i++) begin
            if (sel == SEL_W'(i)) begin
               mem_we    = we[i];
               mem_addr  = addr[i*ADDR_W +: ADDR_W];
               mem_wdata = wdata[i*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: rtl/task_sequencer.sv
// Runs the enabled task engines one at a time in index order and hands the
// shared memory port to the running one. Optional watchdog: TASK_SEQ_TIMEOUT_EN.
module task_sequencer
   import task_seq_pkg::*;
#(
   parameter int NUM_TASKS      = 3,
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            abort,
   input  logic [NUM_TASKS-1:0]            task_mask,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [task_w_f(NUM_TASKS)-1:0]  active_task,
   task_sequencer_if.master                tsk,
   output logic                            mem_we,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_wdata
);

   localparam int TASK_W = task_w_f(NUM_TASKS);

   state_e                 state_q, state_d;
   logic [NUM_TASKS-1:0]   mask_q, mask_d;
   logic [TASK_W-1:0]      idx_q, idx_d;
   logic [NUM_TASKS-1:0]   task_start_q, task_start_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [MAX_TASKS-1:0]   mask_ext;
   logic                   advance;
   int                     nxt;

`ifdef TASK_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             error_q, error_d;
`else
   logic timeout_unused;
   assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      idx_d        = idx_q;
      task_start_d = '0;
      advance      = 1'b0;
`ifdef TASK_SEQ_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      // In IDLE the search runs over the incoming mask from bit 0; in WAIT over
      // the latched mask strictly above the current task.
      mask_ext = '0;
      mask_ext[NUM_TASKS-1:0] = (state_q == ST_IDLE) ? task_mask : mask_q;
      nxt = lowest_set_from(mask_ext, (state_q == ST_IDLE) ? 0 : int'(idx_q) + 1);

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               mask_d  = task_mask;
               advance = 1'b1;
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT;
`ifdef TASK_SEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            if (tsk.task_finish[idx_q]) begin
               advance = 1'b1;
            end
`ifdef TASK_SEQ_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (nxt >= 0) begin
            state_d = ST_LAUNCH;
            idx_d   = TASK_W'(nxt);
            for (int i = 0; i < NUM_TASKS; i++) task_start_d[i] = (nxt == i);
         end else begin
            state_d = ST_DONE;
         end
      end

      // Abort outranks finish and timeout alike.
      if (abort && state_q != ST_IDLE) begin
         state_d      = ST_IDLE;
         idx_d        = idx_q;
         task_start_d = '0;
      end

      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
`ifdef TASK_SEQ_TIMEOUT_EN
      error_d = (state_d == ST_FAULT);
`endif
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         idx_q        <= '0;
         task_start_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef TASK_SEQ_TIMEOUT_EN
         cnt_q        <= '0;
         error_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         idx_q        <= idx_d;
         task_start_q <= task_start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef TASK_SEQ_TIMEOUT_EN
         cnt_q        <= cnt_d;
         error_q      <= error_d;
`endif
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign active_task    = idx_q;
   assign tsk.task_start = task_start_q;
`ifdef TASK_SEQ_TIMEOUT_EN
   assign error          = error_q;
`else
   assign error          = 1'b0;
`endif

   logic mux_en;
   logic mux_we;
   assign mux_en = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

   task_port_mux #(
      .NUM_TASKS (NUM_TASKS),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .SEL_W     (TASK_W)
   ) u_port_mux (
      .en        (mux_en),
      .sel       (idx_q),
      .we        (tsk.task_we),
      .addr      (tsk.task_addr),
      .wdata     (tsk.task_wdata),
      .mem_we    (mux_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata)
   );

   // An aborting cycle must not commit a write, even though the owner still drives one.
   assign mem_we = mux_we & ~abort;

endmodule
